// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and payload types for the register-file
// write-back path.
//   REG_ADDR_W : register address width
//   DATA_W     : register data width
//   wb_entry_t : one queued register write {rd, data}
//   wb_src_t   : write-back source channel, used for the arbiter priority flag
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic {
    SRC_LD  = 1'b0,
    SRC_ALU = 1'b1
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of wb_entry_t with wrapping head/tail pointers.
// Every slot and a per-slot valid mask are exposed so the parent can search
// the queued writes for register matches.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push_i          : write push_entry_i at the tail (caller guarantees room)
//   push_entry_i    : entry to enqueue
//   pop_i           : drop the head entry (caller guarantees non-empty)
//   count_o         : number of valid entries (0..DEPTH)
//   head_o          : slot index of the oldest entry
//   entries_o       : raw storage, indexed by slot
//   valid_o         : per-slot valid mask
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [PTR_W-1:0] head_o,
  output wb_entry_t        entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] off;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + PTR_W'(1);
    if (pop_i)  head_d = head_q + PTR_W'(1);
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i) mem_q[tail_q] <= push_entry_i;
    end
  end

  // A slot is valid when its distance from the head is below the occupancy.
  always_comb begin
    off     = '0;
    valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - head_q;
      valid_o[i] = {1'b0, off} < count_q;
    end
  end

  assign count_o   = count_q;
  assign head_o    = head_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-back queue and arbiter driving the single register
// file write port. ALU and load results enter through valid/ready handshakes,
// are buffered in wb_fifo and retire one write per cycle in enqueue order.
// Optional feature macro: REGFILE_WB_BYPASS_EN -- when defined, reads are
// forwarded from the newest queued write and busy1/busy2 are tied low;
// otherwise reads pass through and busy flags report pending writes.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU result channel
//   ld_valid/ld_ready/ld_rd/ld_data     : load result channel
//   wb_hold                         : suppress retirement this cycle
//   reg_wr, wr_reg, wr_data         : register file write port
//   rd_reg1/2, rf_data1/2           : decode read addresses and raw RF data
//   rd_data1/2                      : read data after optional forwarding
//   busy1/2                         : queued write pending to rd_reg1/2
//   wb_empty                        : queue empty
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic                  wb_hold,
  output logic                  reg_wr,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_reg1,
  input  logic [REG_ADDR_W-1:0] rd_reg2,
  input  logic [DATA_W-1:0]     rf_data1,
  input  logic [DATA_W-1:0]     rf_data2,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     rd_data2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  wb_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_src_t          pri_q, pri_d;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             room, grant_alu, grant_ld, fire_alu, fire_ld, push;
  wb_entry_t        push_entry, head_entry;
  logic [PTR_W-1:0] idx;
  logic             hit1, hit2;
`ifdef REGFILE_WB_BYPASS_EN
  logic [DATA_W-1:0] fwd1, fwd2;
`endif

  // Ready never looks at the same-cycle pop, so a full queue stalls for one cycle even while retiring.
  assign room      = count < CNT_W'(DEPTH);
  assign grant_alu = alu_valid && (!ld_valid || pri_q == SRC_ALU);
  assign grant_ld  = ld_valid && (!alu_valid || pri_q == SRC_LD);
  assign alu_ready = room && !grant_ld;
  assign ld_ready  = room && !grant_alu;
  assign fire_alu  = grant_alu && room;
  assign fire_ld   = grant_ld && room;

  // Writes to r0 complete the handshake but are never queued.
  always_comb begin
    push_entry = '{rd: alu_rd, data: alu_data};
    push       = fire_alu && (alu_rd != '0);
    if (fire_ld) begin
      push_entry = '{rd: ld_rd, data: ld_data};
      push       = ld_rd != '0;
    end
  end

  // Priority flips only after a contended handshake actually completes.
  always_comb begin
    pri_d = pri_q;
    if (alu_valid && ld_valid && room) pri_d = (pri_q == SRC_LD) ? SRC_ALU : SRC_LD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pri_q <= SRC_LD;
    else       pri_q <= pri_d;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (reg_wr),
    .count_o      (count),
    .head_o       (head),
    .entries_o    (entries),
    .valid_o      (valid)
  );

  // Retire port: head entry drives the write, zeroed when nothing is queued.
  assign head_entry = entries[head];
  assign wb_empty   = count == '0;
  assign reg_wr     = !wb_empty && !wb_hold;
  assign wr_reg     = wb_empty ? '0 : head_entry.rd;
  assign wr_data    = wb_empty ? '0 : head_entry.data;

  // Walk oldest to newest so the last match seen is the newest queued write.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
`ifdef REGFILE_WB_BYPASS_EN
    fwd1 = '0;
    fwd2 = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && rd_reg1 != '0 && entries[idx].rd == rd_reg1) begin
        hit1 = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
        fwd1 = entries[idx].data;
`endif
      end
      if (valid[idx] && rd_reg2 != '0 && entries[idx].rd == rd_reg2) begin
        hit2 = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
        fwd2 = entries[idx].data;
`endif
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign rd_data1 = hit1 ? fwd1 : rf_data1;
  assign rd_data2 = hit2 ? fwd2 : rf_data2;
  assign busy1    = 1'b0;
  assign busy2    = 1'b0;
`else
  assign rd_data1 = rf_data1;
  assign rd_data2 = rf_data2;
  assign busy1    = hit1;
  assign busy2    = hit2;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed scenarios plus a randomized run checked
// against a queue-based reference model of the write-back queue.
module tb_regfile_wb_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, ld_valid, ld_ready, wb_hold;
  logic [4:0]  alu_rd, ld_rd, wr_reg, rd_reg1, rd_reg2;
  logic [31:0] alu_data, ld_data, wr_data, rf_data1, rf_data2, rd_data1, rd_data2;
  logic        reg_wr, busy1, busy2, wb_empty;

  int vec  = 0;
  int errs = 0;

  // Reference model state
  ent_t mq[$];
  bit   mpri_alu;
  logic e_alu_ready, e_ld_ready, e_reg_wr, e_empty, e_busy1, e_busy2;
  logic [4:0]  e_wr_reg;
  logic [31:0] e_wr_data, e_rd1, e_rd2;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_hold(wb_hold), .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .busy1(busy1), .busy2(busy2),
    .wb_empty(wb_empty)
  );

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    wb_hold = 0; rd_reg1 = 0; rd_reg2 = 0; rf_data1 = 0; rf_data2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    mq.delete();
    mpri_alu = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  // Expected outputs from the model and the current inputs.
  function automatic void model_eval();
    bit room, g_alu, g_ld, h1, h2;
    logic [31:0] d1, d2;
    room = mq.size() < DEPTH;
    if (alu_valid && ld_valid) begin g_alu = mpri_alu; g_ld = !mpri_alu; end
    else begin g_alu = alu_valid; g_ld = ld_valid; end
    e_alu_ready = room && !g_ld;
    e_ld_ready  = room && !g_alu;
    e_empty     = mq.size() == 0;
    e_reg_wr    = !e_empty && !wb_hold;
    e_wr_reg    = e_empty ? 5'd0 : mq[0].rd;
    e_wr_data   = e_empty ? 32'd0 : mq[0].data;
    h1 = 0; h2 = 0; d1 = 0; d2 = 0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!h1 && rd_reg1 != 0 && mq[i].rd == rd_reg1) begin h1 = 1; d1 = mq[i].data; end
      if (!h2 && rd_reg2 != 0 && mq[i].rd == rd_reg2) begin h2 = 1; d2 = mq[i].data; end
    end
    e_busy1 = BYPASS ? 1'b0 : h1;
    e_busy2 = BYPASS ? 1'b0 : h2;
    e_rd1   = (BYPASS && h1) ? d1 : rf_data1;
    e_rd2   = (BYPASS && h2) ? d2 : rf_data2;
  endfunction

  // Apply the clock edge to the model.
  function automatic void model_commit();
    bit   fa, fl;
    ent_t e;
    fa = alu_valid && e_alu_ready;
    fl = ld_valid && e_ld_ready;
    if (alu_valid && ld_valid && (fa || fl)) mpri_alu = !mpri_alu;
    if (e_reg_wr) void'(mq.pop_front());
    if (fl && ld_rd != 0) begin e.rd = ld_rd; e.data = ld_data; mq.push_back(e); end
    else if (fa && alu_rd != 0) begin e.rd = alu_rd; e.data = alu_data; mq.push_back(e); end
  endfunction

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    #2;
    vec++; if (reg_wr !== 1'b0) begin errs++; $display("FAIL reset_reg_wr: got %b expected 0", reg_wr); end
    vec++; if (wr_reg !== 5'd0) begin errs++; $display("FAIL reset_wr_reg: got %0d expected 0", wr_reg); end
    vec++; if (wr_data !== 32'd0) begin errs++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    vec++; if (wb_empty !== 1'b1) begin errs++; $display("FAIL reset_wb_empty: got %b expected 1", wb_empty); end
    vec++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL reset_alu_ready: got %b expected 1", alu_ready); end
    vec++; if (ld_ready !== 1'b1) begin errs++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
    do_reset();
  endtask

  task automatic test_single_alu();
    do_reset();
    @(negedge clk);
    alu_valid = 1; alu_rd = 5; alu_data = 32'h0000_00AA;
    #1;
    vec++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL single_ready: got %b expected 1", alu_ready); end
    @(negedge clk);
    alu_valid = 0;
    #1;
    vec++; if (reg_wr !== 1'b1) begin errs++; $display("FAIL single_reg_wr: got %b expected 1", reg_wr); end
    vec++; if (wr_reg !== 5'd5) begin errs++; $display("FAIL single_wr_reg: got %0d expected 5", wr_reg); end
    vec++; if (wr_data !== 32'hAA) begin errs++; $display("FAIL single_wr_data: got %h expected aa", wr_data); end
    @(negedge clk);
    #1;
    vec++; if (wb_empty !== 1'b1) begin errs++; $display("FAIL single_empty_after: got %b expected 1", wb_empty); end
    vec++; if (reg_wr !== 1'b0) begin errs++; $display("FAIL single_no_second_wr: got %b expected 0", reg_wr); end
  endtask

  task automatic test_alternate();
    logic [4:0] exp_reg;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ld_valid = (c < 4); ld_rd = 1; ld_data = 32'h11;
      alu_valid = (c < 4); alu_rd = 2; alu_data = 32'h22;
      #1;
      if (c < 4) begin
        vec++; if (ld_ready !== 1'((c % 2) == 0)) begin errs++; $display("FAIL alt_ld_ready c%0d: got %b expected %b", c, ld_ready, (c % 2) == 0); end
        vec++; if (alu_ready !== 1'((c % 2) == 1)) begin errs++; $display("FAIL alt_alu_ready c%0d: got %b expected %b", c, alu_ready, (c % 2) == 1); end
      end
      if (c >= 1 && c <= 4) begin
        exp_reg = ((c % 2) == 1) ? 5'd1 : 5'd2;
        vec++; if (reg_wr !== 1'b1 || wr_reg !== exp_reg) begin errs++; $display("FAIL alt_retire c%0d: got wr=%b reg=%0d expected wr=1 reg=%0d", c, reg_wr, wr_reg, exp_reg); end
      end
      if (c == 5) begin
        vec++; if (wb_empty !== 1'b1) begin errs++; $display("FAIL alt_empty: got %b expected 1", wb_empty); end
      end
    end
  endtask

  task automatic test_hold_full();
    int idx, ret;
    do_reset();
    idx = 0; ret = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      wb_hold = (c < 6);
      alu_valid = (idx < 6); alu_rd = 5'(10 + idx); alu_data = 32'(32'h100 + idx);
      #1;
      if (c < 6) begin
        vec++; if (alu_ready !== 1'(c < 4)) begin errs++; $display("FAIL hold_ready c%0d: got %b expected %b", c, alu_ready, c < 4); end
        vec++; if (reg_wr !== 1'b0) begin errs++; $display("FAIL hold_reg_wr c%0d: got %b expected 0", c, reg_wr); end
      end
      if (c == 6) begin
        vec++; if (alu_ready !== 1'b0) begin errs++; $display("FAIL full_pop_ready: got %b expected 0", alu_ready); end
      end
      if (reg_wr === 1'b1) begin
        vec++; if (wr_reg !== 5'(10 + ret) || wr_data !== 32'(32'h100 + ret)) begin
          errs++; $display("FAIL hold_order #%0d: got r%0d=%h expected r%0d=%h", ret, wr_reg, wr_data, 10 + ret, 32'h100 + ret);
        end
        ret++;
      end
      if (alu_valid && alu_ready) idx++;
    end
    vec++; if (ret != 6) begin errs++; $display("FAIL hold_retired: got %0d expected 6", ret); end
    vec++; if (wb_empty !== 1'b1) begin errs++; $display("FAIL hold_empty: got %b expected 1", wb_empty); end
  endtask

  task automatic test_r0();
    do_reset();
    @(negedge clk);
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    #1;
    vec++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL r0_ready: got %b expected 1", alu_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      alu_valid = 0;
      #1;
      vec++; if (reg_wr !== 1'b0 || wb_empty !== 1'b1) begin errs++; $display("FAIL r0_no_write c%0d: got wr=%b empty=%b expected wr=0 empty=1", c, reg_wr, wb_empty); end
    end
  endtask

  task automatic test_forward();
    logic [31:0] exp_d;
    logic        exp_b;
    exp_d = BYPASS ? 32'h2 : 32'h0;
    exp_b = !BYPASS;
    do_reset();
    wb_hold = 1;
    @(negedge clk); alu_valid = 1; alu_rd = 7; alu_data = 32'h1;
    @(negedge clk); alu_rd = 7; alu_data = 32'h2;
    @(negedge clk); alu_valid = 0;
    rd_reg1 = 7; rf_data1 = 0; rd_reg2 = 0; rf_data2 = 32'h55;
    #1;
    vec++; if (rd_data1 !== exp_d) begin errs++; $display("FAIL fwd_data1: got %h expected %h", rd_data1, exp_d); end
    vec++; if (busy1 !== exp_b) begin errs++; $display("FAIL fwd_busy1: got %b expected %b", busy1, exp_b); end
    vec++; if (busy2 !== 1'b0 || rd_data2 !== 32'h55) begin errs++; $display("FAIL fwd_r0_port2: got busy=%b data=%h expected busy=0 data=55", busy2, rd_data2); end
    @(negedge clk);
    wb_hold = 0;
    #1;
    vec++; if (reg_wr !== 1'b1 || rd_data1 !== exp_d || busy1 !== exp_b) begin
      errs++; $display("FAIL fwd_retire_cycle: got wr=%b data=%h busy=%b expected wr=1 data=%h busy=%b", reg_wr, rd_data1, busy1, exp_d, exp_b);
    end
    repeat (3) @(negedge clk);
    #1;
    vec++; if (busy1 !== 1'b0 || rd_data1 !== 32'h0) begin errs++; $display("FAIL fwd_drained: got busy=%b data=%h expected busy=0 data=0", busy1, rd_data1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb_hold = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      alu_valid = 1; alu_rd = 5'(3 + c); alu_data = 32'(c + 1);
    end
    @(negedge clk);
    alu_valid = 0; wb_hold = 0;
    #1;
    vec++; if (reg_wr !== 1'b1) begin errs++; $display("FAIL midrst_pre_wr: got %b expected 1", reg_wr); end
    #1;
    reset = 1;
    #1;
    vec++; if (reg_wr !== 1'b0) begin errs++; $display("FAIL midrst_reg_wr: got %b expected 0", reg_wr); end
    vec++; if (wb_empty !== 1'b1) begin errs++; $display("FAIL midrst_empty: got %b expected 1", wb_empty); end
    vec++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready: got alu=%b ld=%b expected 1 1", alu_ready, ld_ready); end
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      vec++; if (reg_wr !== 1'b0 || wb_empty !== 1'b1) begin errs++; $display("FAIL midrst_after c%0d: got wr=%b empty=%b expected wr=0 empty=1", c, reg_wr, wb_empty); end
    end
    mq.delete();
    mpri_alu = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      alu_valid = ($urandom_range(0, 2) != 0); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom();
      ld_valid  = ($urandom_range(0, 2) != 0); ld_rd  = 5'($urandom_range(0, 7)); ld_data  = $urandom();
      wb_hold   = ($urandom_range(0, 3) == 0);
      rd_reg1 = 5'($urandom_range(0, 7)); rd_reg2 = 5'($urandom_range(0, 7));
      rf_data1 = $urandom(); rf_data2 = $urandom();
      #1;
      model_eval();
      vec++; if (alu_ready !== e_alu_ready) begin errs++; $display("FAIL rnd_alu_ready c%0d: got %b expected %b", c, alu_ready, e_alu_ready); end
      vec++; if (ld_ready !== e_ld_ready) begin errs++; $display("FAIL rnd_ld_ready c%0d: got %b expected %b", c, ld_ready, e_ld_ready); end
      vec++; if (reg_wr !== e_reg_wr) begin errs++; $display("FAIL rnd_reg_wr c%0d: got %b expected %b", c, reg_wr, e_reg_wr); end
      vec++; if (wr_reg !== e_wr_reg || wr_data !== e_wr_data) begin errs++; $display("FAIL rnd_wr_port c%0d: got r%0d=%h expected r%0d=%h", c, wr_reg, wr_data, e_wr_reg, e_wr_data); end
      vec++; if (wb_empty !== e_empty) begin errs++; $display("FAIL rnd_empty c%0d: got %b expected %b", c, wb_empty, e_empty); end
      vec++; if (busy1 !== e_busy1 || busy2 !== e_busy2) begin errs++; $display("FAIL rnd_busy c%0d: got %b%b expected %b%b", c, busy1, busy2, e_busy1, e_busy2); end
      vec++; if (rd_data1 !== e_rd1 || rd_data2 !== e_rd2) begin errs++; $display("FAIL rnd_rd_data c%0d: got %h %h expected %h %h", c, rd_data1, rd_data2, e_rd1, e_rd2); end
      model_commit();
    end
    @(negedge clk);
    idle_inputs();
    repeat (DEPTH + 2) @(negedge clk);
    #1;
    vec++; if (wb_empty !== 1'b1) begin errs++; $display("FAIL rnd_drain: got %b expected 1", wb_empty); end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_alternate();
    test_hold_full();
    test_r0();
    test_forward();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
